// File: rtl/pc_pkg.sv
// Shared definitions for the instruction-fetch controller: datapath width,
// PC step, reset PC default and the three-state fetch FSM encoding.
package pc_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // A PC is usable only when it points at a 32-bit word boundary.
    function automatic logic is_word_aligned(input logic [PC_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_plus4.sv
// Sequential-PC incrementer: adds PC_STEP, wrapping modulo 2^PC_W.
module pc_plus4
    import pc_pkg::*;
(
    input  logic [PC_W-1:0] pc_in,
    output logic [PC_W-1:0] pc_out
);

    // The carry out of the top bit is dropped on purpose so the PC wraps.
    assign pc_out = pc_in + PC_STEP;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: walks the PC, issues one memory request at a
// time, holds each returned word until decode takes it, and honours
// branch/jump redirects with priority over memory and decode handshakes.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            misalign_err
);

    fetch_state_e    state_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_next_s;
    logic            redirect_ok_s;
    logic            redirect_bad_s;

    pc_plus4 u_pc_plus4 (
        .pc_in  (pc_r),
        .pc_out (pc_next_s)
    );

    // The fetch address is always the live PC; only imem_req qualifies it.
    assign imem_addr = pc_r;

    // Split a redirect into an accepted (aligned) or rejected (misaligned) one.
    always_comb begin
        redirect_ok_s  = 1'b0;
        redirect_bad_s = 1'b0;
        if (redirect_valid) begin
            if (is_word_aligned(redirect_pc)) begin
                redirect_ok_s = 1'b1;
            end else begin
                redirect_bad_s = 1'b1;
            end
        end else begin
            redirect_ok_s  = 1'b0;
            redirect_bad_s = 1'b0;
        end
    end

    // Fetch FSM with PC, output-holding registers and registered handshakes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            imem_req     <= 1'b0;
            out_valid    <= 1'b0;
            misalign_err <= 1'b0;
            out_instr    <= {PC_W{1'b0}};
            out_pc       <= {PC_W{1'b0}};
        end else begin
            // A rejected redirect is flagged for exactly one cycle.
            misalign_err <= redirect_bad_s;
            case (state_r)
                IDLE: begin
                    if (redirect_ok_s) begin
                        pc_r <= redirect_pc;
                    end
                    if (run) begin
                        state_r  <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                FETCH: begin
                    if (redirect_ok_s) begin
                        // Any data acked this cycle belongs to the old stream.
                        pc_r     <= redirect_pc;
                        state_r  <= FETCH;
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        out_instr <= imem_rdata;
                        out_pc    <= pc_r;
                        pc_r      <= pc_next_s;
                        state_r   <= HOLD;
                        imem_req  <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        state_r  <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_ok_s || out_ready) begin
                        // Either delivered or flushed; run decides whether to continue.
                        if (redirect_ok_s) begin
                            pc_r <= redirect_pc;
                        end
                        out_valid <= 1'b0;
                        if (run) begin
                            state_r  <= FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state_r  <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end else begin
                        state_r   <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    imem_req  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    int checks;
    int failures;

    // Reference model: "fetching" = a request is outstanding, "holding" = a word awaits decode.
    logic [31:0] m_pc;
    logic        m_fetching;
    logic        m_holding;
    logic        m_err;
    logic [31:0] m_out_pc;
    logic [31:0] m_out_instr;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_step();
        logic ok;
        if (!reset) begin
            m_pc        = 32'h0000_0000;
            m_fetching  = 1'b0;
            m_holding   = 1'b0;
            m_err       = 1'b0;
            m_out_pc    = 32'h0;
            m_out_instr = 32'h0;
        end else begin
            ok    = redirect_valid && ((redirect_pc % 32'd4) == 32'd0);
            m_err = redirect_valid && !ok;
            if (m_fetching) begin
                if (ok) begin
                    m_pc = redirect_pc;
                end else if (imem_ack) begin
                    m_out_instr = imem_rdata;
                    m_out_pc    = m_pc;
                    m_pc        = m_pc + 32'd4;
                    m_fetching  = 1'b0;
                    m_holding   = 1'b1;
                end
            end else if (m_holding) begin
                if (ok || out_ready) begin
                    if (ok) m_pc = redirect_pc;
                    m_holding  = 1'b0;
                    m_fetching = run;
                end
            end else begin
                if (ok) m_pc = redirect_pc;
                m_fetching = run;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b1; imem_ack = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rdata = 32'h0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Leaves the DUT in its first FETCH cycle at pc = 4*n.
    task automatic go_to_fetch(input int n);
        do_reset();
        run = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            imem_rdata = $urandom;
            tick();
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0042; imem_rdata = 32'h1234_5678;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", misalign_err); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        redirect_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] r;
        do_reset();
        run = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin failures++; $display("FAIL stream_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, 32'(4 * k)); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_gap: got valid=%b expected 0", out_valid); end
            r = $urandom; imem_rdata = r;
            tick();
            checks++; if (out_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL stream_valid: got valid=%b req=%b expected valid=1 req=0", out_valid, imem_req); end
            checks++; if (out_pc !== 32'(4 * k) || out_instr !== r) begin failures++; $display("FAIL stream_data: got pc=%h instr=%h expected pc=%h instr=%h", out_pc, out_instr, 32'(4 * k), r); end
            tick();
        end
    endtask

    task automatic test_ack_delay();
        logic [31:0] r;
        go_to_fetch(2);
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL delay_hold: cycle %0d got req=%b addr=%h expected req=1 addr=8", i, imem_req, imem_addr); end
            if (i == 3) begin
                r = $urandom; imem_rdata = r; imem_ack = 1'b1;
            end else begin
                imem_rdata = $urandom;
            end
            tick();
        end
        checks++; if (out_valid !== 1'b1 || out_instr !== r || out_pc !== 32'h8) begin failures++; $display("FAIL delay_data: got valid=%b instr=%h pc=%h expected valid=1 instr=%h pc=8", out_valid, out_instr, out_pc, r); end
    endtask

    task automatic test_redirect_fetch();
        logic [31:0] r;
        go_to_fetch(1);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_fetch_drop: got valid=%b expected 0", out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_fetch_addr: got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr); end
        r = $urandom; imem_rdata = r;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== r) begin failures++; $display("FAIL redir_fetch_next: got valid=%b pc=%h instr=%h expected valid=1 pc=100 instr=%h", out_valid, out_pc, out_instr, r); end
    endtask

    task automatic test_redirect_hold();
        logic [31:0] r;
        go_to_fetch(0);
        out_ready = 1'b0; r = $urandom; imem_rdata = r;
        tick();
        imem_ack = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_instr !== r || out_pc !== 32'h0) begin failures++; $display("FAIL hold_stable: got valid=%b instr=%h pc=%h expected valid=1 instr=%h pc=0", out_valid, out_instr, out_pc, r); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_flush: got valid=%b expected 0", out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL hold_refetch: got req=%b addr=%h expected req=1 addr=200", imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick();
        checks++; if (out_pc !== 32'h200) begin failures++; $display("FAIL hold_newpc: got %h expected 200", out_pc); end
        out_ready = 1'b1;
    endtask

    task automatic test_misalign();
        go_to_fetch(1);
        imem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL misalign_pulse: got %b expected 1", misalign_err); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL misalign_pc: got req=%b addr=%h expected req=1 addr=4", imem_req, imem_addr); end
        tick();
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL misalign_width: got %b expected 0", misalign_err); end
        imem_ack = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin failures++; $display("FAIL misalign_deliver: got valid=%b pc=%h expected valid=1 pc=4", out_valid, out_pc); end
        tick();
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL misalign_seq: got %h expected 8", imem_addr); end
    endtask

    task automatic test_run_low();
        go_to_fetch(1);
        run = 1'b0; imem_ack = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL runlow_fetch: got req=%b expected 1", imem_req); end
        imem_ack = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL runlow_hold: got valid=%b expected 1", out_valid); end
        tick();
        tick();
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h8) begin failures++; $display("FAIL runlow_idle: got req=%b valid=%b addr=%h expected req=0 valid=0 addr=8", imem_req, out_valid, imem_addr); end
        run = 1'b1;
    endtask

    task automatic test_wrap_and_reset();
        go_to_fetch(0);
        imem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_redir: got %h expected fffffffc", imem_addr); end
        imem_ack = 1'b1;
        tick();
        checks++; if (out_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_outpc: got %h expected fffffffc", out_pc); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        tick();
        tick();
        imem_ack = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL midfetch_reset: got req=%b valid=%b addr=%h expected req=0 valid=0 addr=0", imem_req, out_valid, imem_addr); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(63) != 0);
            run            = ($urandom_range(9) != 0);
            imem_ack       = 1'($urandom_range(1));
            out_ready      = 1'($urandom_range(1));
            imem_rdata     = $urandom;
            redirect_valid = ($urandom_range(7) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(15) == 0) redirect_pc = 32'hFFFF_FFF8;
            if ($urandom_range(3) != 0) redirect_pc[1:0] = 2'b00;
            tick();
            checks++; if (imem_req !== m_fetching) begin failures++; $display("FAIL rnd_req: cycle %0d got %b expected %b", c, imem_req, m_fetching); end
            checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_addr: cycle %0d got %h expected %h", c, imem_addr, m_pc); end
            checks++; if (out_valid !== m_holding) begin failures++; $display("FAIL rnd_valid: cycle %0d got %b expected %b", c, out_valid, m_holding); end
            checks++; if (misalign_err !== m_err) begin failures++; $display("FAIL rnd_err: cycle %0d got %b expected %b", c, misalign_err, m_err); end
            checks++; if (out_pc !== m_out_pc || out_instr !== m_out_instr) begin failures++; $display("FAIL rnd_out: cycle %0d got pc=%h instr=%h expected pc=%h instr=%h", c, out_pc, out_instr, m_out_pc, m_out_instr); end
        end
        redirect_valid = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0; run = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rdata = 32'h0;
        test_reset();
        test_stream();
        test_ack_delay();
        test_redirect_fetch();
        test_redirect_hold();
        test_misalign();
        test_run_low();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
